mdio_receptor_param: RTL and testbench

MDIO_RECEPTOR_PARAM -- requirements
Module: mdio_receptor_param

---
 rtl/mdio_receptor_param_if.sv | 30 +++
 rtl/mdio_receptor_param.sv | 191 +++++++++++++++++++
 tb/tb_mdio_receptor_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_receptor_param_if.sv
// mdio_receptor_param_if
//   Bundles the station-manager side of the MDIO receptor.
//   master : station manager / testbench (drives mdio_out, mdio_oe)
//   slave  : mdio_receptor_param (drives read data, strobes, address, write data)
//   mdio_out   manager serial data       mdio_oe    manager drive enable
//   mdio_in    receptor read data        mdio_in_en high while mdio_in is valid
//   mdio_done  end-of-frame pulse        addr       register address of last frame
//   wr_data    last write data           wr_stb     write strobe
//   frame_err  malformed/rejected frame pulse
interface mdio_receptor_param_if;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        mdio_in_en;
  logic        mdio_done;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        frame_err;

  modport master (
    output mdio_out, mdio_oe,
    input  mdio_in, mdio_in_en, mdio_done, addr, wr_data, wr_stb, frame_err
  );

  modport slave (
    input  mdio_out, mdio_oe,
    output mdio_in, mdio_in_en, mdio_done, addr, wr_data, wr_stb, frame_err
  );
endinterface

// File: rtl/mdio_receptor_param.sv
// mdio_receptor_param
//   Clause-22 style MDIO slave with a small internal 16-bit register file.
//   Ports:
//     mdc   : management clock, all logic on the rising edge
//     reset : asynchronous, active-low reset
//     bus   : mdio_receptor_param_if.slave (serial in/out, strobes, addr, wr_data)
//
//   state   | meaning
//   --------+------------------------------------------------------
//   S_IDLE  | no preamble ones counted yet
//   S_PRE   | counting consecutive preamble ones
//   S_ST    | first ST bit (0) seen, waiting for second ST bit (1)
//   S_OP    | collecting 2 opcode bits
//   S_PHYAD | collecting 5 PHY address bits
//   S_REGAD | collecting 5 register address bits
//   S_TA    | turnaround (checked for writes, ignored for reads)
//   S_WDATA | collecting 16 write data bits
//   S_RDATA | shifting 16 read data bits out
module mdio_receptor_param #(
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter int         REG_DEPTH    = 32,
  parameter int         PREAMBLE_LEN = 32,
  parameter bit         BCAST_EN     = 1'b0
) (
  input  logic                        mdc,
  input  logic                        reset,
  mdio_receptor_param_if.slave        bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
  } state_t;

  state_t       state, state_nx;
  logic [4:0]   bit_cnt;
  logic [4:0]   regad;
  logic [5:0]   pre_cnt;
  logic [14:0]  shreg;
  logic [15:0]  rd_sh;
  logic [15:0]  rd_word;
  logic [15:0]  wdata_nx;
  logic         op_wr;
  logic [511:0] regs_flat;
  logic         bit_in, oe;
  logic [4:0]   field5;
  logic         phy_hit, bcast_hit, pre_ok;
  logic         err_nx, wr_nx, rd_load, rd_shift, rd_end;

  assign bit_in    = bus.mdio_out;
  assign oe        = bus.mdio_oe;
  // The shift register always holds the most recent bits, so a field's value
  // is the last N-1 stored bits plus the one being sampled now.
  assign field5    = {shreg[3:0], bit_in};
  assign wdata_nx  = {shreg, bit_in};
  assign pre_ok    = (int'(pre_cnt) >= PREAMBLE_LEN);
  assign phy_hit   = (field5 == PHY_ADDR);
  assign bcast_hit = BCAST_EN && (field5 == 5'd0);
  assign rd_word   = (int'(regad) < REG_DEPTH) ? regs_flat[{regad, 4'b0000} +: 16] : 16'h0000;

  always_ff @(posedge mdc or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_PRE: begin
        if (!oe)         state_nx = S_IDLE;
        else if (bit_in) state_nx = S_PRE;
        else if (pre_ok) state_nx = S_ST;
        else             state_nx = S_IDLE;
      end
      S_ST: state_nx = (oe && bit_in) ? S_OP : S_IDLE;
      S_OP: begin
        if (!oe) state_nx = S_IDLE;
        else if (bit_cnt == 5'd1) state_nx = (shreg[0] ^ bit_in) ? S_PHYAD : S_IDLE;
      end
      S_PHYAD: begin
        if (!oe) state_nx = S_IDLE;
        else if (bit_cnt == 5'd4) state_nx = (phy_hit || (bcast_hit && op_wr)) ? S_REGAD : S_IDLE;
      end
      S_REGAD: begin
        if (!oe) state_nx = S_IDLE;
        else if (bit_cnt == 5'd4) state_nx = S_TA;
      end
      S_TA: begin
        if (op_wr) begin
          if (!oe)                            state_nx = S_IDLE;
          else if (bit_cnt == 5'd0 && !bit_in) state_nx = S_IDLE;
          else if (bit_cnt == 5'd1)           state_nx = bit_in ? S_IDLE : S_WDATA;
        end else if (bit_cnt == 5'd1) begin
          // read turnaround: manager may already have released the line
          state_nx = S_RDATA;
        end
      end
      S_WDATA: if (!oe || bit_cnt == 5'd15) state_nx = S_IDLE;
      S_RDATA: if (oe || bit_cnt == 5'd15) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    err_nx   = 1'b0;
    wr_nx    = 1'b0;
    rd_load  = 1'b0;
    rd_shift = 1'b0;
    rd_end   = 1'b0;
    case (state)
      S_ST:    err_nx = oe && !bit_in;
      S_OP:    err_nx = oe && (bit_cnt == 5'd1) && !(shreg[0] ^ bit_in);
      S_PHYAD: err_nx = oe && (bit_cnt == 5'd4) && !op_wr && !phy_hit && bcast_hit;
      S_TA: begin
        if (op_wr) err_nx = oe && (((bit_cnt == 5'd0) && !bit_in) || ((bit_cnt == 5'd1) && bit_in));
        else       rd_load = (bit_cnt == 5'd1);
      end
      S_WDATA: wr_nx = oe && (bit_cnt == 5'd15);
      S_RDATA: begin
        if (oe)                    err_nx   = 1'b1;
        else if (bit_cnt == 5'd15) rd_end   = 1'b1;
        else                       rd_shift = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mdc or negedge reset) begin
    if (!reset) begin
      bit_cnt        <= 5'd0;
      pre_cnt        <= 6'd0;
      shreg          <= 15'd0;
      rd_sh          <= 16'd0;
      op_wr          <= 1'b0;
      regad          <= 5'd0;
      bus.mdio_in    <= 1'b0;
      bus.mdio_in_en <= 1'b0;
      bus.mdio_done  <= 1'b0;
      bus.addr       <= 5'd0;
      bus.wr_data    <= 16'd0;
      bus.wr_stb     <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bit_cnt <= (state_nx != state) ? 5'd0 : bit_cnt + 5'd1;
      shreg   <= wdata_nx[14:0];
      // Only uninterrupted driven ones count; anything else restarts the preamble.
      if ((state == S_IDLE || state == S_PRE) && oe && bit_in) begin
        if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
      end else begin
        pre_cnt <= 6'd0;
      end
      if (state == S_OP && bit_cnt == 5'd1)    op_wr <= ~shreg[0];
      if (state == S_REGAD && bit_cnt == 5'd4) regad <= field5;

      bus.mdio_done <= wr_nx | rd_end;
      bus.wr_stb    <= wr_nx;
      bus.frame_err <= err_nx;
      if (wr_nx) begin
        bus.wr_data <= wdata_nx;
        bus.addr    <= regad;
      end
      if (rd_end) bus.addr <= regad;

      if (rd_load) begin
        bus.mdio_in_en <= 1'b1;
        bus.mdio_in    <= rd_word[15];
        rd_sh          <= {rd_word[14:0], 1'b0};
      end else if (rd_shift) begin
        bus.mdio_in <= rd_sh[15];
        rd_sh       <= {rd_sh[14:0], 1'b0};
      end else if (rd_end || err_nx) begin
        bus.mdio_in_en <= 1'b0;
        bus.mdio_in    <= 1'b0;
      end
    end
  end

  // Unimplemented addresses read as zero and have no storage.
  for (genvar g = 0; g < 32; g++) begin : g_reg
    if (g < REG_DEPTH) begin : g_impl
      logic [15:0] q;
      always_ff @(posedge mdc or negedge reset) begin
        if (!reset)                        q <= 16'h0000;
        else if (wr_nx && regad == 5'(g)) q <= wdata_nx;
      end
      assign regs_flat[g*16 +: 16] = q;
    end else begin : g_none
      assign regs_flat[g*16 +: 16] = 16'h0000;
    end
  end

endmodule

// File: tb/tb_mdio_receptor_param.sv
// tb_mdio_receptor_param
//   Directed bench for mdio_receptor_param. dut_a: PHY 13, 8 registers,
//   32-bit preamble, broadcast writes enabled. dut_b: PHY 2, 32 registers,
//   preamble suppression. sel_b routes the manager enable to one DUT.
module tb_mdio_receptor_param;
  logic mdc = 1'b0;
  logic reset = 1'b0;
  logic mo = 1'b1;
  logic oe = 1'b0;
  logic sel_b = 1'b0;
  int   vec = 0;
  int   miss = 0;
  int   n_wr = 0, n_done = 0, n_err = 0, n_bad = 0;
  logic p_wr = 1'b0, p_done = 1'b0, p_err = 1'b0;

  mdio_receptor_param_if ifa ();
  mdio_receptor_param_if ifb ();

  assign ifa.mdio_out = mo;
  assign ifb.mdio_out = mo;
  assign ifa.mdio_oe  = oe & ~sel_b;
  assign ifb.mdio_oe  = oe & sel_b;

  mdio_receptor_param #(.PHY_ADDR(5'd13), .REG_DEPTH(8), .PREAMBLE_LEN(32), .BCAST_EN(1'b1))
    dut_a (.mdc(mdc), .reset(reset), .bus(ifa));
  mdio_receptor_param #(.PHY_ADDR(5'd2), .REG_DEPTH(32), .PREAMBLE_LEN(0), .BCAST_EN(1'b0))
    dut_b (.mdc(mdc), .reset(reset), .bus(ifb));

  wire        o_in   = sel_b ? ifb.mdio_in    : ifa.mdio_in;
  wire        o_en   = sel_b ? ifb.mdio_in_en : ifa.mdio_in_en;
  wire        o_done = sel_b ? ifb.mdio_done  : ifa.mdio_done;
  wire        o_wr   = sel_b ? ifb.wr_stb     : ifa.wr_stb;
  wire        o_err  = sel_b ? ifb.frame_err  : ifa.frame_err;
  wire [4:0]  o_addr = sel_b ? ifb.addr       : ifa.addr;
  wire [15:0] o_wd   = sel_b ? ifb.wr_data    : ifa.wr_data;

  always #5 mdc = ~mdc;

  // Pulse observer: counts strobe cycles and flags overlap or stretched pulses.
  always @(negedge mdc) begin
    if (o_wr) n_wr++;
    if (o_done) n_done++;
    if (o_err) n_err++;
    if (o_err && (o_wr || o_done)) n_bad++;
    if ((o_wr && p_wr) || (o_done && p_done) || (o_err && p_err)) n_bad++;
    p_wr = o_wr; p_done = o_done; p_err = o_err;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clk_bit(input logic b, input logic e);
    @(negedge mdc); mo = b; oe = e;
    @(posedge mdc); #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) clk_bit(v[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) clk_bit(1'b1, 1'b0);
  endtask

  task automatic hdr(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg);
    send(32'hFFFF_FFFF, pre);
    send(32'(2'b01), 2);
    send(32'(op), 2);
    send(32'(phy), 5);
    send(32'(rg), 5);
  endtask

  task automatic wr_frame(input int pre, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
    hdr(pre, 2'b01, phy, rg);
    send(32'(2'b10), 2);
    send(32'(d), 16);
  endtask

  // Manager releases the line for both TA bits and samples 16 data cycles.
  task automatic rd_frame(input int pre, input logic [4:0] phy, input logic [4:0] rg,
                          output logic [15:0] d, output int en_cnt);
    hdr(pre, 2'b10, phy, rg);
    clk_bit(1'b0, 1'b0);
    clk_bit(1'b0, 1'b0);
    en_cnt = 0;
    d = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      d[15 - i] = o_in;
      if (o_en === 1'b1) en_cnt++;
      clk_bit(1'b1, 1'b0);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge mdc);
    vec++; if (ifa.mdio_in !== 1'b0) begin miss++; $display("FAIL rst_in: got %b want 0", ifa.mdio_in); end
    vec++; if (ifa.mdio_in_en !== 1'b0) begin miss++; $display("FAIL rst_in_en: got %b want 0", ifa.mdio_in_en); end
    vec++; if (ifa.mdio_done !== 1'b0) begin miss++; $display("FAIL rst_done: got %b want 0", ifa.mdio_done); end
    vec++; if (ifa.wr_stb !== 1'b0) begin miss++; $display("FAIL rst_wr_stb: got %b want 0", ifa.wr_stb); end
    vec++; if (ifa.frame_err !== 1'b0) begin miss++; $display("FAIL rst_err: got %b want 0", ifa.frame_err); end
    vec++; if (ifa.addr !== 5'd0) begin miss++; $display("FAIL rst_addr: got %0d want 0", ifa.addr); end
    vec++; if (ifa.wr_data !== 16'h0000) begin miss++; $display("FAIL rst_wr_data: got %h want 0000", ifa.wr_data); end
    @(negedge mdc); reset = 1'b1;
    idle(2);
  endtask

  task automatic test_write;
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    wr_frame(32, 5'd13, 5'd5, 16'h43AE);
    vec++; if (o_wr !== 1'b1) begin miss++; $display("FAIL wr_stb: got %b want 1", o_wr); end
    vec++; if (o_done !== 1'b1) begin miss++; $display("FAIL wr_done: got %b want 1", o_done); end
    vec++; if (o_addr !== 5'd5) begin miss++; $display("FAIL wr_addr: got %0d want 5", o_addr); end
    vec++; if (o_wd !== 16'h43AE) begin miss++; $display("FAIL wr_data: got %h want 43ae", o_wd); end
    idle(1);
    vec++; if (o_wr !== 1'b0) begin miss++; $display("FAIL wr_stb_width: got %b want 0", o_wr); end
    vec++; if (n_wr - w0 !== 1) begin miss++; $display("FAIL wr_count: got %0d want 1", n_wr - w0); end
    vec++; if (n_done - d0 !== 1) begin miss++; $display("FAIL wr_done_count: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_read;
    logic [15:0] d; int en; int d0, e0;
    d0 = n_done; e0 = n_err;
    rd_frame(32, 5'd13, 5'd5, d, en);
    vec++; if (d !== 16'h43AE) begin miss++; $display("FAIL rd_data: got %h want 43ae", d); end
    vec++; if (en !== 16) begin miss++; $display("FAIL rd_en_cycles: got %0d want 16", en); end
    vec++; if (o_en !== 1'b0 || o_in !== 1'b0) begin miss++; $display("FAIL rd_release: got en=%b in=%b want 0 0", o_en, o_in); end
    vec++; if (o_done !== 1'b1) begin miss++; $display("FAIL rd_done: got %b want 1", o_done); end
    vec++; if (o_addr !== 5'd5) begin miss++; $display("FAIL rd_addr: got %0d want 5", o_addr); end
    idle(2);
    vec++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin miss++; $display("FAIL rd_pulses: got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0); end
  endtask

  task automatic test_phy_mismatch;
    logic [15:0] d; int en; int w0, e0;
    w0 = n_wr; e0 = n_err;
    wr_frame(32, 5'd3, 5'd5, 16'h1234);
    idle(2);
    vec++; if (n_wr - w0 !== 0 || n_err - e0 !== 0) begin miss++; $display("FAIL phy_miss_pulses: got wr=%0d err=%0d want 0 0", n_wr - w0, n_err - e0); end
    vec++; if (o_wd !== 16'h43AE) begin miss++; $display("FAIL phy_miss_wr_data: got %h want 43ae", o_wd); end
    rd_frame(32, 5'd13, 5'd5, d, en);
    vec++; if (d !== 16'h43AE) begin miss++; $display("FAIL phy_miss_reg: got %h want 43ae", d); end
    idle(2);
  endtask

  task automatic test_errors;
    int w0, e0;
    w0 = n_wr; e0 = n_err;
    send(32'hFFFF_FFFF, 32); send(32'(2'b01), 2); send(32'(2'b11), 2);
    vec++; if (o_err !== 1'b1) begin miss++; $display("FAIL op11_err: got %b want 1", o_err); end
    idle(3);
    vec++; if (n_err - e0 !== 1) begin miss++; $display("FAIL op11_err_count: got %0d want 1", n_err - e0); end
    e0 = n_err;
    hdr(32, 2'b01, 5'd13, 5'd6); send(32'(2'b11), 2);
    vec++; if (o_err !== 1'b1) begin miss++; $display("FAIL ta11_err: got %b want 1", o_err); end
    idle(3);
    vec++; if (n_err - e0 !== 1 || n_wr - w0 !== 0) begin miss++; $display("FAIL ta11_pulses: got err=%0d wr=%0d want 1 0", n_err - e0, n_wr - w0); end
    wr_frame(32, 5'd13, 5'd6, 16'hA5C3);
    vec++; if (o_wr !== 1'b1 || o_wd !== 16'hA5C3) begin miss++; $display("FAIL after_err_wr: got stb=%b data=%h want 1 a5c3", o_wr, o_wd); end
    idle(2);
    w0 = n_wr; e0 = n_err;
    wr_frame(31, 5'd13, 5'd6, 16'hFFFF);
    idle(2);
    vec++; if (n_wr - w0 !== 0 || n_err - e0 !== 0) begin miss++; $display("FAIL short_pre: got wr=%0d err=%0d want 0 0", n_wr - w0, n_err - e0); end
  endtask

  task automatic test_depth;
    logic [15:0] d; int en;
    wr_frame(32, 5'd13, 5'd20, 16'hBEEF);
    vec++; if (o_wr !== 1'b1 || o_addr !== 5'd20) begin miss++; $display("FAIL depth_wr: got stb=%b addr=%0d want 1 20", o_wr, o_addr); end
    idle(2);
    rd_frame(32, 5'd13, 5'd20, d, en);
    vec++; if (d !== 16'h0000 || en !== 16) begin miss++; $display("FAIL depth_rd: got %h en=%0d want 0000 16", d, en); end
    idle(2);
  endtask

  task automatic test_bcast;
    logic [15:0] d; int en; int e0, d0;
    wr_frame(32, 5'd0, 5'd7, 16'h0F0F);
    vec++; if (o_wr !== 1'b1 || o_addr !== 5'd7) begin miss++; $display("FAIL bcast_wr: got stb=%b addr=%0d want 1 7", o_wr, o_addr); end
    idle(2);
    rd_frame(32, 5'd13, 5'd7, d, en);
    vec++; if (d !== 16'h0F0F) begin miss++; $display("FAIL bcast_reg: got %h want 0f0f", d); end
    idle(2);
    e0 = n_err; d0 = n_done;
    hdr(32, 2'b10, 5'd0, 5'd7);
    idle(20);
    vec++; if (n_err - e0 !== 1 || n_done - d0 !== 0) begin miss++; $display("FAIL bcast_rd: got err=%0d done=%0d want 1 0", n_err - e0, n_done - d0); end
  endtask

  task automatic test_rd_abort;
    hdr(32, 2'b10, 5'd13, 5'd5);
    clk_bit(1'b0, 1'b0); clk_bit(1'b0, 1'b0); clk_bit(1'b0, 1'b0);
    clk_bit(1'b1, 1'b1);
    vec++; if (o_en !== 1'b0 || o_err !== 1'b1) begin miss++; $display("FAIL rd_abort: got en=%b err=%b want 0 1", o_en, o_err); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    logic [15:0] d; int en; int w0;
    hdr(32, 2'b01, 5'd13, 5'd5); send(32'(2'b10), 2); send(32'h0000_00FF, 8);
    #2 reset = 1'b0;
    #1;
    vec++; if (ifa.addr !== 5'd0 || ifa.wr_data !== 16'h0000) begin miss++; $display("FAIL rst_mid_regs: got addr=%0d data=%h want 0 0000", ifa.addr, ifa.wr_data); end
    vec++; if (ifa.wr_stb !== 1'b0 || ifa.mdio_done !== 1'b0 || ifa.frame_err !== 1'b0 || ifa.mdio_in_en !== 1'b0) begin miss++; $display("FAIL rst_mid_strobes: got %b%b%b%b want 0000", ifa.wr_stb, ifa.mdio_done, ifa.frame_err, ifa.mdio_in_en); end
    @(negedge mdc); reset = 1'b1;
    w0 = n_wr;
    send(32'h0000_00FF, 8);
    idle(2);
    vec++; if (n_wr - w0 !== 0) begin miss++; $display("FAIL rst_mid_nowr: got %0d want 0", n_wr - w0); end
    rd_frame(32, 5'd13, 5'd5, d, en);
    vec++; if (d !== 16'h0000) begin miss++; $display("FAIL rst_mid_reg: got %h want 0000", d); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [15:0] d; int en;
    sel_b = 1'b1;
    idle(2);
    wr_frame(0, 5'd2, 5'd3, 16'h1357);
    vec++; if (o_wr !== 1'b1 || o_wd !== 16'h1357) begin miss++; $display("FAIL nopre_wr: got stb=%b data=%h want 1 1357", o_wr, o_wd); end
    rd_frame(0, 5'd2, 5'd3, d, en);
    vec++; if (d !== 16'h1357 || en !== 16) begin miss++; $display("FAIL nopre_rd: got %h en=%0d want 1357 16", d, en); end
    wr_frame(0, 5'd2, 5'd4, 16'h2468);
    vec++; if (o_wr !== 1'b1 || o_addr !== 5'd4) begin miss++; $display("FAIL b2b_wr: got stb=%b addr=%0d want 1 4", o_wr, o_addr); end
    idle(2);
    sel_b = 1'b0;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phy_mismatch();
    test_errors();
    test_depth();
    test_bcast();
    test_rd_abort();
    test_reset_mid();
    test_back_to_back();
    vec++; if (n_bad !== 0) begin miss++; $display("FAIL pulse_overlap: got %0d want 0", n_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
